// File: rtl/apb_slave_regs.sv
// APB3 completer over a bank of NUM_REGS 32-bit registers, with WAIT_STATES wait cycles per transfer.
// Define APB_SLV_PSLVERR_EN to answer unmapped or misaligned addresses with pslverr_o.
module apb_slave_regs #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic [31:0]              paddr_i,
    input  logic                     pwrite_i,
    input  logic [31:0]              pwdata_i,
    output logic                     pready_o,
    output logic [31:0]              prdata_o,
    output logic                     pslverr_o,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [9:0]         idx;
    logic               hit;
    logic               complete;
    logic               wr_en;
    logic               rd_en;
    logic [NUM_REGS-1:0] wr_sel;
    logic [31:0]        rd_data;
    logic [31:0]        regs [NUM_REGS];

    assign idx      = paddr_i[11:2];
    assign hit      = (paddr_i[31:12] == BASE_ADDR[31:12]) && (paddr_i[1:0] == 2'b00)
                      && ({22'd0, idx} < 32'(NUM_REGS));
    assign complete = (state == ACCESS) && psel_i && penable_i && (cnt == 4'd0);
    assign wr_en    = complete && pwrite_i && hit;
    assign rd_en    = complete && !pwrite_i && hit;

    assign pready_o = complete;
    assign prdata_o = rd_data;

`ifdef APB_SLV_PSLVERR_EN
    assign pslverr_o = complete && !hit;
`else
    assign pslverr_o = 1'b0;
`endif

    // A fresh setup seen while already in ACCESS restarts the wait count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state <= ACCESS;
                        cnt   <= 4'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state <= IDLE;
                    end else if (!penable_i) begin
                        cnt <= 4'(WAIT_STATES);
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_sel  = '0;
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == 10'(k)) begin
                wr_sel[k] = wr_en;
                if (rd_en) begin
                    rd_data = regs[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
            wr_pulse_o <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_sel[k]) begin
                    regs[k] <= pwdata_i;
                end
            end
            wr_pulse_o <= wr_sel;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[32*g +: 32] = regs[g];
    end

endmodule
